// File: rtl/chess_pkg.sv
// Shared chess encodings for the systolic move generator cells.
// Holds piece codes, direction indices, move flag bits and width helpers.
package chess_pkg;

    // Piece type codes; colour travels separately as the MSB of cpiece.
    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] PAWN    = 3'd1;
    localparam logic [2:0] KNIGHT  = 3'd2;
    localparam logic [2:0] BISHOP  = 3'd3;
    localparam logic [2:0] ROOK    = 3'd4;
    localparam logic [2:0] QUEEN   = 3'd5;
    localparam logic [2:0] KING    = 3'd6;
    localparam logic [2:0] NOTUSED = 3'd7;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    // Sliding directions 0..7, knight jumps 8..15.
    localparam int DIR_U   = 0;
    localparam int DIR_UR  = 1;
    localparam int DIR_R   = 2;
    localparam int DIR_DR  = 3;
    localparam int DIR_D   = 4;
    localparam int DIR_DL  = 5;
    localparam int DIR_L   = 6;
    localparam int DIR_UL  = 7;
    localparam int DIR_KN0 = 8;
    localparam int NDIR    = 16;

    // Move flag bit positions.
    localparam int F_INVALID = 6;
    localparam int F_PROMOTE = 5;
    localparam int F_PAWN    = 4;
    localparam int F_PAWN2   = 3;
    localparam int F_EP      = 2;
    localparam int F_CASTLE  = 1;
    localparam int F_CAPTURE = 0;
    localparam int FLAG_W    = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_PROP,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int ray_w(input int cw, input int pw);
        return 2 * cw + pw;
    endfunction

    function automatic int move_w(input int cw);
        return FLAG_W + 4 * cw;
    endfunction

    // LSB of slot d in a packed bus of w-bit words.
    function automatic int slot_lsb(input int d, input int w);
        return d * w;
    endfunction

endpackage

// File: rtl/square_cell_gen2_if.sv
// Valid/ready move port of a board cell.
// Ports: mv_data (move word), mv_valid (head present), mv_ready (pop).
interface square_cell_gen2_if #(
    parameter int MOVE_W = 19
);
    logic [MOVE_W-1:0] mv_data;
    logic              mv_valid;
    logic              mv_ready;

    modport master (
        output mv_data,
        output mv_valid,
        input  mv_ready
    );

    modport slave (
        input  mv_data,
        input  mv_valid,
        output mv_ready
    );
endinterface

// File: rtl/move_fifo.sv
// Synchronous first-word-fall-through FIFO for generated moves.
// Ports: push/din write, pop/dout read head, full/empty status, reset/flush.
module move_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= din;
    end

    assign dout  = r_mem[r_rp];
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == '0);
endmodule

// File: rtl/square_cell_gen2.sv
// Board-square cell: seeds its piece, accepts neighbour rays, queues moves.
// Ports: clk/reset/start, xpos/ypos/cpiece, ray_in/out, hold_in/out, mv, done, overflow.
module square_cell_gen2
    import chess_pkg::*;
#(
    parameter int  COORD_W      = 3,
    parameter int  PIECE_W      = 3,
    parameter int  FIFO_DEPTH   = 16,
    parameter int  QUIET_CYCLES = 2,
    localparam int RAY_W        = ray_w(COORD_W, PIECE_W),
    localparam int MOVE_W       = move_w(COORD_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COORD_W-1:0]    xpos,
    input  logic [COORD_W-1:0]    ypos,
    input  logic [PIECE_W:0]      cpiece,
    input  logic [NDIR*RAY_W-1:0] ray_in,
    output logic [NDIR*RAY_W-1:0] ray_out,
    input  logic [7:0]            hold_in,
    output logic [7:0]            hold_out,
    square_cell_gen2_if.master    mv,
    output logic                  done,
    output logic                  overflow
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    state_t               r_state;
    state_t               w_next;
    logic [QW-1:0]        r_quiet;
    logic [NDIR-1:0]      r_pend_v;
    logic [MOVE_W-1:0]    r_pend [NDIR];

    logic [PIECE_W-1:0]   w_type;
    logic                 w_empty_sq;
    logic                 w_black;
    logic                 w_ok;
    logic                 w_proc;
    logic                 w_idle;
    logic [RAY_W-1:0]     w_void;
    logic [COORD_W-1:0]   w_rx [NDIR];
    logic [COORD_W-1:0]   w_ry [NDIR];
    logic [PIECE_W-1:0]   w_rp [NDIR];
    logic [NDIR-1:0]      w_live;
    logic [NDIR-1:0]      w_gen;
    logic [NDIR-1:0]      w_fwd;
    logic [FLAG_W-1:0]    w_flags [NDIR];
    logic [MOVE_W-1:0]    w_move [NDIR];
    logic [NDIR-1:0]      w_seed;
    logic [NDIR*RAY_W-1:0] w_ray_nx;
    logic [7:0]           w_hold_nx;
    logic [3:0]           w_sel;
    logic                 w_has;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_fifo_empty;
    logic [MOVE_W-1:0]    w_fifo_dout;
    logic [NDIR-1:0]      w_freed;
    logic [NDIR-1:0]      w_accept;
    logic [NDIR-1:0]      w_drop;

    assign w_type     = cpiece[PIECE_W-1:0];
    assign w_empty_sq = (w_type == PIECE_W'(EMPTY));
    assign w_black    = (cpiece[PIECE_W] == BLACK) && !w_empty_sq;
    assign w_ok       = w_empty_sq || w_black;
    assign w_void     = {xpos, ypos, PIECE_W'(EMPTY)};
    assign w_proc     = (r_state == S_PROP) || (r_state == S_DRAIN)
                     || (r_state == S_DONE);

    always_comb begin
        for (int d = 0; d < NDIR; d++) begin
            {w_rx[d], w_ry[d], w_rp[d]} = ray_in[slot_lsb(d, RAY_W) +: RAY_W];
            w_live[d] = (w_rp[d] != PIECE_W'(EMPTY));
        end
    end

    // Acceptance and forwarding rules per incoming direction.
    always_comb begin
        w_gen = '0;
        w_fwd = '0;
        for (int d = 0; d < NDIR; d++) begin
            w_flags[d] = '0;
            if (w_live[d]) begin
                if (d >= DIR_KN0) begin
                    w_gen[d] = w_ok;
                    w_flags[d][F_CAPTURE] = w_black;
                end else if (w_rp[d] == PIECE_W'(PAWN)) begin
                    if (d == DIR_U) begin
                        w_gen[d] = w_empty_sq;
                        w_flags[d][F_PAWN]    = 1'b1;
                        w_flags[d][F_PAWN2]   = (ypos == COORD_W'(3))
                                             && (w_ry[d] == COORD_W'(1));
                        w_flags[d][F_PROMOTE] = &ypos;
                        // Double step continues through rank 2 only.
                        w_fwd[d] = w_empty_sq && (ypos == COORD_W'(2))
                                && (w_ry[d] == COORD_W'(1));
                    end else if (d == DIR_UR || d == DIR_UL) begin
                        w_gen[d] = w_black;
                        w_flags[d][F_PAWN]    = 1'b1;
                        w_flags[d][F_CAPTURE] = 1'b1;
                        w_flags[d][F_PROMOTE] = &ypos;
                    end
                end else begin
                    w_gen[d] = w_ok;
                    w_flags[d][F_CAPTURE] = w_black;
                    w_fwd[d] = w_empty_sq && (
                        (w_rp[d] == PIECE_W'(QUEEN)) ||
                        (w_rp[d] == PIECE_W'(BISHOP) && d[0]) ||
                        (w_rp[d] == PIECE_W'(ROOK) && !d[0]));
                end
            end
            w_move[d] = {w_flags[d], w_rx[d], w_ry[d], xpos, ypos};
        end
    end

    always_comb begin
        w_seed = '0;
        if (cpiece[PIECE_W] == WHITE) begin
            unique case (1'b1)
                w_type == PIECE_W'(PAWN):   w_seed = 16'h0083;
                w_type == PIECE_W'(KNIGHT): w_seed = 16'hFF00;
                w_type == PIECE_W'(BISHOP): w_seed = 16'h00AA;
                w_type == PIECE_W'(ROOK):   w_seed = 16'h0055;
                w_type == PIECE_W'(QUEEN),
                w_type == PIECE_W'(KING):   w_seed = 16'h00FF;
                default:                    w_seed = '0;
            endcase
        end
    end

    always_comb begin
        w_ray_nx = {NDIR{w_void}};
        if (!start) begin
            for (int d = 0; d < NDIR; d++) begin
                if (r_state == S_SEED && w_seed[d])
                    w_ray_nx[slot_lsb(d, RAY_W) +: RAY_W] = {xpos, ypos, w_type};
                else if (w_proc && w_fwd[d])
                    w_ray_nx[slot_lsb(d, RAY_W) +: RAY_W] =
                        ray_in[slot_lsb(d, RAY_W) +: RAY_W];
            end
        end
        for (int d = 0; d < 8; d++)
            w_hold_nx[d] = (w_ray_nx[slot_lsb(d, RAY_W) +: PIECE_W]
                            != PIECE_W'(EMPTY));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ray_out  <= {NDIR{w_void}};
            hold_out <= '0;
        end else begin
            ray_out  <= w_ray_nx;
            hold_out <= w_hold_nx;
        end
    end

    // Lowest-index pending slot goes to the FIFO first.
    always_comb begin
        w_sel = '0;
        w_has = 1'b0;
        for (int d = NDIR - 1; d >= 0; d--) begin
            if (r_pend_v[d]) begin
                w_sel = 4'(d);
                w_has = 1'b1;
            end
        end
    end

    assign w_pop    = mv.mv_valid && mv.mv_ready;
    assign w_push   = w_has && (!w_full || w_pop);
    assign w_freed  = w_push ? (NDIR'(1) << w_sel) : '0;
    // A slot being pushed this cycle is free to take a new move.
    assign w_drop   = w_gen & {NDIR{w_proc}} & r_pend_v & ~w_freed;
    assign w_accept = w_gen & {NDIR{w_proc}} & ~w_drop;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_pend_v <= '0;
        end else begin
            for (int d = 0; d < NDIR; d++) begin
                if (w_accept[d]) begin
                    r_pend_v[d] <= 1'b1;
                    r_pend[d]   <= w_move[d];
                end else if (w_freed[d]) begin
                    r_pend_v[d] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start)
            overflow <= 1'b0;
        else if (|w_drop)
            overflow <= 1'b1;
    end

    move_fifo #(
        .WIDTH (MOVE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (start),
        .push  (w_push),
        .din   (r_pend[w_sel]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_fifo_empty)
    );

    assign mv.mv_data  = w_fifo_dout;
    assign mv.mv_valid = !w_fifo_empty;

    assign w_idle = !(|w_live) && (hold_in == '0) && (r_pend_v == '0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_SEED:  w_next = S_PROP;
            S_PROP:
                if (w_idle && r_quiet == QW'(QUIET_CYCLES - 1))
                    w_next = S_DRAIN;
            S_DRAIN:
                if (|w_live)
                    w_next = S_PROP;
                else if (w_fifo_empty)
                    w_next = S_DONE;
            S_DONE:
                if (|w_live)
                    w_next = S_PROP;
            default: w_next = S_IDLE;
        endcase
        if (start)
            w_next = S_SEED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_quiet <= '0;
        end else begin
            r_state <= w_next;
            r_quiet <= (r_state == S_PROP && w_idle && w_next == S_PROP)
                     ? r_quiet + QW'(1) : '0;
        end
    end

    assign done = (r_state == S_DONE);
endmodule
